// File: rtl/vout_timing_gen.sv
// ---------------------------------------------------------------------------
// vout_timing_gen
//   Video output timing generator for the HDMI path (single vout_clk domain).
//   Produces the raster counters, HDMI hs/vs/de, the frame-buffer FIFO read
//   strobe, and expands the FIFO's RGB565 words to RGB888 aligned with de.
//
// Ports
//   vout_clk     in   1   pixel clock
//   rst          in   1   asynchronous reset, active-high
//   en           in   1   timing enable (0 parks the raster at start of V front porch)
//   vout_rd_req  out  1   FIFO read strobe, one word per active pixel
//   vout_data    in   16  RGB565 word, valid RD_LATENCY clocks after the strobe
//   vout_vs      out  1   undelayed frame sync to the buffer controller, active-high
//   vout_width   out  12  constant H_ACTIVE
//   vout_height  out  12  constant V_ACTIVE
//   hdmi_hs      out  1   horizontal sync, level HS_POL during sync
//   hdmi_vs      out  1   vertical sync, level VS_POL during sync
//   hdmi_de      out  1   data enable
//   hdmi_r/g/b   out  8   pixel components
//   pattern_sel  in   1   colour-bar select (only with VOUT_COLOR_BAR_EN)
//
// Build option
//   VOUT_COLOR_BAR_EN : adds pattern_sel and an 8-bar test pattern source.
//
// RD_LATENCY must be in 1..4.
// ---------------------------------------------------------------------------
module vout_timing_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int RD_LATENCY = 1
) (
  input  logic        vout_clk,
  input  logic        rst,
  input  logic        en,
  output logic        vout_rd_req,
  input  logic [15:0] vout_data,
  output logic        vout_vs,
  output logic [11:0] vout_width,
  output logic [11:0] vout_height,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic        hdmi_de,
  output logic [7:0]  hdmi_r,
  output logic [7:0]  hdmi_g,
  output logic [7:0]  hdmi_b
`ifdef VOUT_COLOR_BAR_EN
  ,
  input  logic        pattern_sel
`endif
);

  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [11:0]         h_cnt, v_cnt;
  logic                de_raw, hs_raw, vs_raw;
  logic                de_q, hs_q, vs_q;
  logic [RD_LATENCY:0] de_pipe, hs_pipe, vs_pipe;
  logic [23:0]         rgb_d, rgb_q;

  assign vout_width  = H_ACT;
  assign vout_height = V_ACT;

  // Raster counters. Disabled/reset state is the first line of the vertical
  // front porch, so a fresh start always passes through vs before line 0.
  // NOTE: clocked state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= V_ACT;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= V_ACT;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_raw = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Stage 0 (read strobe / internal vs), then RD_LATENCY+1 stages so that
  // de reaches the output together with the captured FIFO word. With en low
  // stage 0 takes inactive values and the later stages drain naturally.
  // NOTE: pipeline flops are reset too, so hs/vs/de are defined the moment rst asserts.
  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
      rgb_q   <= '0;
    end else begin
      de_q    <= en & de_raw;
      hs_q    <= en & hs_raw;
      vs_q    <= en & vs_raw;
      de_pipe <= {de_pipe[RD_LATENCY-1:0], de_q};
      hs_pipe <= {hs_pipe[RD_LATENCY-1:0], hs_q};
      vs_pipe <= {vs_pipe[RD_LATENCY-1:0], vs_q};
      rgb_q   <= rgb_d;
    end
  end

`ifdef VOUT_COLOR_BAR_EN
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

  logic                      pattern_q;
  logic [RD_LATENCY:0][2:0]  bar_pipe;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Source select only changes on the frame wrap, never mid-frame.
  // bar_pipe[0] lines up with de_q; bar_pipe[RD_LATENCY] with the RGB capture.
  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      pattern_q <= 1'b0;
      bar_pipe  <= '0;
    end else begin
      if (en && (h_cnt == H_LAST) && (v_cnt == V_LAST))
        pattern_q <= pattern_sel;
      bar_pipe[0] <= 3'(h_cnt / BAR_W);
      for (int i = 1; i <= RD_LATENCY; i++)
        bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  assign vout_rd_req = de_q & ~pattern_q;
`else
  assign vout_rd_req = de_q;
`endif

  // RGB565 -> RGB888 by MSB replication; blank whenever the aligned de is low.
  // NOTE: rgb_d gets its default first, so no branch can leave it unassigned (no latch).
  always_comb begin
    rgb_d = '0;
    if (de_pipe[RD_LATENCY-1]) begin
      rgb_d = {vout_data[15:11], vout_data[15:13],
               vout_data[10:5],  vout_data[10:9],
               vout_data[4:0],   vout_data[4:2]};
`ifdef VOUT_COLOR_BAR_EN
      if (pattern_q)
        rgb_d = bar_rgb(bar_pipe[RD_LATENCY]);
`endif
    end
  end

  assign vout_vs = vs_q;
  assign hdmi_de = de_pipe[RD_LATENCY];
  assign hdmi_hs = HS_POL ? hs_pipe[RD_LATENCY] : ~hs_pipe[RD_LATENCY];
  assign hdmi_vs = VS_POL ? vs_pipe[RD_LATENCY] : ~vs_pipe[RD_LATENCY];
  assign hdmi_r  = rgb_q[23:16];
  assign hdmi_g  = rgb_q[15:8];
  assign hdmi_b  = rgb_q[7:0];

endmodule

// File: tb/tb_vout_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vout_timing_gen
//   Self-checking bench for vout_timing_gen using a small raster
//   (8/2/2/2 x 4/1/1/1, RD_LATENCY=2, VS_POL=0). A FIFO model answers the
//   read strobe with RGB565 words (0xF800, 0x07E0, then random). Expected
//   outputs come from the raster position computed arithmetically from the
//   number of enabled clocks, plus a history of per-clock raw timing values.
// ---------------------------------------------------------------------------
module tb_vout_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int LAT = 2;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int HOLD_POS = VA * HT;
  localparam int FIRST_RD = FRAME - HOLD_POS + 1;
  localparam int WIN = FRAME + FRAME - HOLD_POS;

  logic        vout_clk, rst, en;
  logic        vout_rd_req;
  logic [15:0] vout_data;
  logic        vout_vs;
  logic [11:0] vout_width, vout_height;
  logic        hdmi_hs, hdmi_vs, hdmi_de;
  logic [7:0]  hdmi_r, hdmi_g, hdmi_b;

  vout_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .RD_LATENCY(LAT)
  ) dut (
    .vout_clk(vout_clk), .rst(rst), .en(en),
    .vout_rd_req(vout_rd_req), .vout_data(vout_data), .vout_vs(vout_vs),
    .vout_width(vout_width), .vout_height(vout_height),
    .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de),
    .hdmi_r(hdmi_r), .hdmi_g(hdmi_g), .hdmi_b(hdmi_b)
  );

  initial vout_clk = 1'b0;
  always #5 vout_clk = ~vout_clk;

  int tests, fails;

  // Reference state
  int          pos;   // raster position (v*HT+h) the counters hold before the next edge
  int          cyc;
  bit          hist_de [8];
  bit          hist_hs [8];
  bit          hist_vs [8];
  logic [15:0] preload [$];
  logic [15:0] sched_word [$];
  int          sched_due [$];
  logic [23:0] exp_rgb [$];
  logic        rd_seen;

  // Aggregate observations
  int step_no, rd_count, first_rd_step, last_rd_step, vs_rise_step, vs_first_step;
  int vs_run, vs_width, hs_rise_prev, hs_period, hs_run, hs_width;
  int de_rises, de_run, de_width, beat_n;
  logic [23:0] beat0, beat1;
  bit prev_vs, prev_hs, prev_de;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb888(input logic [15:0] d);
    int r, g, b;
    r = (int'(d) >> 11) & 31;
    g = (int'(d) >> 5) & 63;
    b = int'(d) & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  task automatic raw_of(input int p, output bit de, output bit hs, output bit vs);
    int h, v;
    h  = p % HT;
    v  = p / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
  endtask

  task automatic model_reset();
    pos = HOLD_POS;
    for (int i = 0; i < 8; i++) begin
      hist_de[i] = 1'b0; hist_hs[i] = 1'b0; hist_vs[i] = 1'b0;
    end
    sched_word.delete();
    sched_due.delete();
    exp_rgb.delete();
    rd_seen = 1'b0;
  endtask

  task automatic model_edge(input bit en_v);
    bit d, h, v;
    logic [15:0] w;
    d = 1'b0; h = 1'b0; v = 1'b0;
    if (en_v) raw_of(pos, d, h, v);
    for (int i = 7; i > 0; i--) begin
      hist_de[i] = hist_de[i-1]; hist_hs[i] = hist_hs[i-1]; hist_vs[i] = hist_vs[i-1];
    end
    hist_de[0] = d; hist_hs[0] = h; hist_vs[0] = v;
    pos = en_v ? (pos + 1) % FRAME : HOLD_POS;
    cyc++;
    // FIFO model: strobe seen at this edge -> word appears LAT-1 edges later
    if (rd_seen === 1'b1) begin
      w = (preload.size() != 0) ? preload.pop_front() : 16'($urandom);
      sched_word.push_back(w);
      sched_due.push_back(cyc + LAT - 1);
      exp_rgb.push_back(rgb888(w));
    end
  endtask

  task automatic drive_data();
    if (sched_due.size() != 0 && sched_due[0] == cyc) begin
      vout_data = sched_word.pop_front();
      void'(sched_due.pop_front());
    end else begin
      vout_data = 16'($urandom);
    end
  endtask

  task automatic compare();
    check("vout_rd_req", vout_rd_req, hist_de[0]);
    check("vout_vs", vout_vs, hist_vs[0]);
    check("hdmi_de", hdmi_de, hist_de[LAT+1]);
    check("hdmi_hs", hdmi_hs, hist_hs[LAT+1] ? HSP : !HSP);
    check("hdmi_vs", hdmi_vs, hist_vs[LAT+1] ? VSP : !VSP);
    if (hist_de[LAT+1]) begin
      check("rgb_avail", exp_rgb.size() != 0, 1);
      if (exp_rgb.size() != 0) check("rgb", {hdmi_r, hdmi_g, hdmi_b}, exp_rgb.pop_front());
    end else begin
      check("rgb_blank", {hdmi_r, hdmi_g, hdmi_b}, 0);
    end
    rd_seen = vout_rd_req;
  endtask

  task automatic clear_stats();
    step_no = 0; rd_count = 0; first_rd_step = -1; last_rd_step = -1;
    vs_rise_step = -1; vs_first_step = -1; vs_run = 0; vs_width = -1;
    hs_rise_prev = -1; hs_period = -1; hs_run = 0; hs_width = -1;
    de_rises = 0; de_run = 0; de_width = -1; beat_n = 0; beat0 = '0; beat1 = '0;
    prev_vs = 1'b0; prev_hs = 1'b0; prev_de = 1'b0;
  endtask

  task automatic observe();
    bit hs_act, vs_act, de_act;
    step_no++;
    hs_act = (hdmi_hs === HSP);
    vs_act = (vout_vs === 1'b1);
    de_act = (hdmi_de === 1'b1);
    if (vout_rd_req === 1'b1) begin
      rd_count++;
      if (first_rd_step < 0) first_rd_step = step_no;
      last_rd_step = step_no;
    end
    if (vs_act && !prev_vs) begin
      vs_rise_step = step_no;
      if (vs_first_step < 0) vs_first_step = step_no;
      vs_run = 0;
    end
    if (vs_act) vs_run++; else if (prev_vs) vs_width = vs_run;
    if (hs_act && !prev_hs) begin
      if (hs_rise_prev >= 0) hs_period = step_no - hs_rise_prev;
      hs_rise_prev = step_no;
      hs_run = 0;
    end
    if (hs_act) hs_run++; else if (prev_hs) hs_width = hs_run;
    if (de_act && !prev_de) begin de_rises++; de_run = 0; end
    if (de_act) begin
      if (beat_n == 0) beat0 = {hdmi_r, hdmi_g, hdmi_b};
      else if (beat_n == 1) beat1 = {hdmi_r, hdmi_g, hdmi_b};
      beat_n++;
      de_run++;
    end else if (prev_de) begin
      de_width = de_run;
    end
    prev_vs = vs_act; prev_hs = hs_act; prev_de = de_act;
  endtask

  // One clock: drive en, model the edge, answer as the FIFO, check at negedge.
  task automatic step(input bit en_v);
    en = en_v;
    @(posedge vout_clk);
    model_edge(en_v);
    #1 drive_data();
    @(negedge vout_clk);
    compare();
    observe();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_req"}, vout_rd_req, 0);
    check({tag, "_vout_vs"}, vout_vs, 0);
    check({tag, "_de"}, hdmi_de, 0);
    check({tag, "_rgb"}, {hdmi_r, hdmi_g, hdmi_b}, 0);
    check({tag, "_hs"}, hdmi_hs, !HSP);
    check({tag, "_vs"}, hdmi_vs, !VSP);
    check({tag, "_width"}, vout_width, HA);
    check({tag, "_height"}, vout_height, VA);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b1; en = 1'b0; vout_data = '0;
    model_reset();
    clear_stats();
    preload.push_back(16'hF800);
    preload.push_back(16'h07E0);

    // Reset state
    repeat (3) @(negedge vout_clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Start from reset with en=1: first frame timing
    clear_stats();
    repeat (WIN) step(1'b1);
    check("first_rd_step", first_rd_step, FIRST_RD);
    check("rd_per_frame", rd_count, HA * VA);
    check("hs_period", hs_period, HT);
    check("hs_width", hs_width, HSW);
    check("de_lines", de_rises, VA);
    check("de_width", de_width, HA);
    check("vs_width", vs_width, VSW * HT);
    check("vs_after_last_active", vs_rise_step - last_rd_step, (VFP + 1) * HT - HA + 1);
    check("first_beat", beat0, 24'hFF0000);
    check("second_beat", beat1, 24'h00FF00);

    // Steady state with random pixel words
    repeat (2 * FRAME) step(1'b1);

    // Drop en at v=2, h=3 (mid active line)
    for (int i = 0; i < FRAME && pos != 2 * HT + 3; i++) step(1'b1);
    check("pre_drop_de_raw", vout_rd_req, 1);
    step(1'b0);
    repeat (LAT + 1) step(1'b0);
    check("de_drain", hdmi_de, 0);
    repeat (5) step(1'b0);

    // Re-enable: vs precedes any read strobe
    clear_stats();
    repeat (WIN) step(1'b1);
    check("reen_first_rd", first_rd_step, FIRST_RD);
    check("reen_vs_first", (vs_first_step > 0) && (vs_first_step < first_rd_step), 1);
    check("reen_rd_count", rd_count, HA * VA);

    // Random enable toggling
    for (int i = 0; i < 400; i++) step($urandom_range(0, 15) != 0);

    // Asynchronous reset in the middle of an active line
    for (int i = 0; i < 2 * FRAME && vout_rd_req !== 1'b1; i++) step(1'b1);
    check("pre_rst_rd_req", vout_rd_req, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("midline_rst");
    model_reset();
    repeat (2) @(negedge vout_clk);
    check_reset_values("rst_held");
    rst = 1'b0;
    clear_stats();
    repeat (WIN) step(1'b1);
    check("post_rst_first_rd", first_rd_step, FIRST_RD);
    check("post_rst_rd_count", rd_count, HA * VA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
